// File: rtl/imem_port_arbiter.sv
// Arbitrates one synchronous single-port instruction RAM between CPU fetch and a loader/debug port.
// Fetch owns the RAM by default; loader bursts are bounded by LD_MAX before one forced fetch cycle.
module imem_port_arbiter #(
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH),
    parameter int LD_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   fetch_instr,
    output logic          fetch_valid,
    output logic          stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [31:0]   ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_gnt,
    output logic [31:0]   ld_rdata,
    output logic          ld_rvalid,
    output logic          ld_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int HW = (LD_MAX > 2) ? $clog2(LD_MAX) : 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [HW-1:0] hold_cnt_r;
    logic [HW-1:0] hold_cnt_s;

    logic fetch_inr_s;
    logic ld_inr_s;
    logic fetch_acc_s;
    logic ld_acc_s;
    logic fetch_valid_r;
    logic fetch_inr_r;
    logic ld_rvalid_r;
    logic ld_inr_r;
    logic ld_err_r;
    logic unused_addr_bits_s;

    // Word address must fall inside the RAM; byte-offset bits are ignored.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return ({2'b00, addr[31:2]} < 32'(DEPTH));
    endfunction

    assign unused_addr_bits_s = ^{fetch_addr[1:0], ld_addr[1:0]};

    assign fetch_inr_s = addr_in_range(fetch_addr);
    assign ld_inr_s    = addr_in_range(ld_addr);
    assign ld_gnt      = (state_r == S_LOAD);
    assign fetch_acc_s = fetch_req & ~ld_gnt;
    assign ld_acc_s    = ld_req & ld_gnt;
    assign stall       = fetch_req & ld_gnt;
    assign mem_we      = ld_acc_s & ld_we & ld_inr_s;
    assign mem_wdata   = ld_wdata;
    assign fetch_valid = fetch_valid_r;
    assign ld_rvalid   = ld_rvalid_r;
    assign ld_err      = ld_err_r;

    // RAM address steering follows the current owner.
    always_comb begin
        if (ld_gnt) begin
            mem_addr = ld_addr[AW+1:2];
        end else begin
            mem_addr = fetch_addr[AW+1:2];
        end
    end

    // Next-state and hold counter; the counter saturates at LD_MAX-1 and forces one cool cycle.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            S_FETCH: begin
                if (ld_req) begin
                    state_s    = S_LOAD;
                    hold_cnt_s = {HW{1'b0}};
                end else begin
                    state_s    = S_FETCH;
                end
            end
            S_LOAD: begin
                if (!ld_req) begin
                    state_s    = S_FETCH;
                    hold_cnt_s = {HW{1'b0}};
                end else if (hold_cnt_r == HW'(LD_MAX - 1)) begin
                    state_s    = S_COOL;
                end else begin
                    hold_cnt_s = hold_cnt_r + {{(HW-1){1'b0}}, 1'b1};
                end
            end
            S_COOL: begin
                hold_cnt_s = {HW{1'b0}};
                if (ld_req) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_FETCH;
                end
            end
            default: begin
                state_s    = S_FETCH;
                hold_cnt_s = {HW{1'b0}};
            end
        endcase
    end

    // State and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_FETCH;
            hold_cnt_r <= {HW{1'b0}};
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    // Response pipeline: remembers what was accepted so the RAM data can be qualified next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_r <= 1'b0;
            fetch_inr_r   <= 1'b0;
            ld_rvalid_r   <= 1'b0;
            ld_inr_r      <= 1'b0;
            ld_err_r      <= 1'b0;
        end else begin
            fetch_valid_r <= fetch_acc_s;
            fetch_inr_r   <= fetch_acc_s & fetch_inr_s;
            ld_rvalid_r   <= ld_acc_s & ~ld_we;
            ld_inr_r      <= ld_acc_s & ~ld_we & ld_inr_s;
            ld_err_r      <= ld_acc_s & ~ld_inr_s;
        end
    end

    // Out-of-range fetches read as NOP; out-of-range loader reads return zero.
    always_comb begin
        if (fetch_valid_r && fetch_inr_r) begin
            fetch_instr = mem_rdata;
        end else begin
            fetch_instr = 32'h0000_0000;
        end
        if (ld_rvalid_r && ld_inr_r) begin
            ld_rdata = mem_rdata;
        end else begin
            ld_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: behavioural RAM, reference model with scoreboard
// queues for fetch and loader-read results, plus directed checks of the key scenarios.
module tb_imem_port_arbiter;

    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int LD_MAX = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_addr = 32'h0;
    logic [31:0]   fetch_instr;
    logic          fetch_valid;
    logic          stall;
    logic          ld_req = 1'b0;
    logic          ld_we = 1'b0;
    logic [31:0]   ld_addr = 32'h0;
    logic [31:0]   ld_wdata = 32'h0;
    logic          ld_gnt;
    logic [31:0]   ld_rdata;
    logic          ld_rvalid;
    logic          ld_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = 32'h0;
    logic [31:0]   ram [0:DEPTH-1];

    int errors = 0;
    int checks = 0;

    // reference model
    int          m_state;   // 0 fetch owns, 1 loader granted, 2 cool
    int          m_run;     // grant cycles so far in the current loader run
    bit          m_fv, m_rv, m_err;
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] fetch_q[$];
    logic [31:0] ld_q[$];

    imem_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .LD_MAX(LD_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
        .fetch_valid(fetch_valid), .stall(stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid), .ld_err(ld_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 2) < DEPTH;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 15) return 32'h1110_0003;
        if (i == 2)  return 32'h0000_0124;
        return {16'hA5C3, 16'(i)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_fv = 0; m_rv = 0; m_err = 0;
        fetch_q.delete(); ld_q.delete();
    endtask

    task automatic drive_idle();
        fetch_req = 1'b0; fetch_addr = 32'h0; ld_req = 1'b0; ld_we = 1'b0;
        ld_addr = 32'h0; ld_wdata = 32'h0;
    endtask

    // One clock: drive at negedge, check before the next posedge, then advance the model.
    task automatic cycle(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                         input logic [31:0] la, input logic [31:0] wd);
        bit f_acc, l_acc;
        logic [31:0] e;
        @(negedge clk);
        fetch_req = fr; fetch_addr = fa; ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = wd;
        #2;
        check_val("ld_gnt", ld_gnt, (m_state == 1));
        check_val("stall", stall, fr && (m_state == 1));
        check_val("mem_we", mem_we, (m_state == 1) && lr && lw && in_rng(la));
        check_val("fetch_valid", fetch_valid, m_fv);
        check_val("ld_rvalid", ld_rvalid, m_rv);
        check_val("ld_err", ld_err, m_err);
        if (m_fv) begin
            e = fetch_q.pop_front();
            check_val("fetch_instr", fetch_instr, e);
        end
        if (m_rv) begin
            e = ld_q.pop_front();
            check_val("ld_rdata", ld_rdata, e);
        end
        f_acc = fr && (m_state != 1);
        l_acc = lr && (m_state == 1);
        m_fv  = f_acc;
        if (f_acc) fetch_q.push_back(in_rng(fa) ? ref_mem[fa[AW+1:2]] : 32'h0);
        m_rv  = l_acc && !lw;
        if (m_rv) ld_q.push_back(in_rng(la) ? ref_mem[la[AW+1:2]] : 32'h0);
        m_err = l_acc && !in_rng(la);
        if (l_acc && lw && in_rng(la)) ref_mem[la[AW+1:2]] = wd;
        case (m_state)
            0: if (lr) begin m_state = 1; m_run = 1; end
            1: begin
                if (!lr) m_state = 0;
                else if (m_run >= LD_MAX) m_state = 2;
                else m_run++;
            end
            default: begin
                if (lr) begin m_state = 1; m_run = 1; end
                else m_state = 0;
            end
        endcase
    endtask

    initial begin
        bit gnt_log [0:40];
        int open_fetch;
        model_reset();
        // preload RAM while in reset
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = AW'(i); pl_data = init_word(i); ref_mem[i] = init_word(i);
        end
        @(negedge clk);
        pl_en = 1'b0;
        #1;
        check_val("rst_gnt", ld_gnt, 1'b0);
        check_val("rst_fv", fetch_valid, 1'b0);
        check_val("rst_rv", ld_rvalid, 1'b0);
        check_val("rst_err", ld_err, 1'b0);
        check_val("rst_we", mem_we, 1'b0);
        check_val("rst_instr", fetch_instr, 32'h0);
        check_val("rst_rdata", ld_rdata, 32'h0);
        rst_n = 1'b1;

        // 1: basic fetch
        cycle(1'b1, 32'h3C, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("t1_fv", fetch_valid, 1'b1);
        check_val("t1_instr", fetch_instr, 32'h1110_0003);
        cycle(1'b1, 32'hFC, 1'b0, 1'b0, 32'h0, 32'h0);   // last in-range word

        // 2: loader write while fetching
        cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        check_val("t2_gnt", ld_gnt, 1'b1);
        check_val("t2_stall", stall, 1'b1);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("t2_ram", ram[4], 32'hDEAD_BEEF);
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("t2_fetch", fetch_instr, 32'hDEAD_BEEF);

        // 3: long loader burst against continuous fetch
        open_fetch = 0;
        for (int i = 0; i <= 40; i++) begin
            cycle(1'b1, 32'h3C, 1'b1, 1'b0, 32'h04, 32'h0);
            gnt_log[i] = ld_gnt;
            if (i > 0 && !stall) open_fetch++;
        end
        for (int i = 0; i <= 40; i++)
            check_val($sformatf("t3_gnt[%0d]", i), gnt_log[i], !(i == 0 || i == 17 || i == 34));
        check_val("t3_fetch_slots", open_fetch, 2);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // 4: out-of-range loader write and fetch
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
        check_val("t4_we", mem_we, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("t4_err", ld_err, 1'b1);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("t4_err_pulse", ld_err, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("t4_fv", fetch_valid, 1'b1);
        check_val("t4_nop", fetch_instr, 32'h0);

        // 5: loader read
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h08, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h08, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("t5_rv", ld_rvalid, 1'b1);
        check_val("t5_rdata", ld_rdata, 32'h0000_0124);

        // random mix
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 32'h11F) & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 32'h11F) & 32'hFFFF_FFFC, $urandom);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // 6: asynchronous reset mid-burst
        cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFE_0001);
        cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFE_0002);
        cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFE_0003);
        check_val("t6_we_pre", mem_we, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_val("t6_gnt", ld_gnt, 1'b0);
        check_val("t6_we", mem_we, 1'b0);
        model_reset();
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'h3C, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("t6_fv_early", fetch_valid, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_val("t6_fv", fetch_valid, 1'b1);
        check_val("t6_ram", ram[8], 32'hCAFE_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
